// File: rtl/vram_if.sv
// Bus bundle between the video generator, the CPU port and the video RAM.
// The arbiter takes the slave view; whatever drives requests and models the RAM takes the master view.
interface vram_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 12
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic [15:0]       cpu_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q;

  // cpu_req/cpu_ack: the CPU raises cpu_req with cpu_we/cpu_addr/cpu_wdata stable and holds
  // all of them until the single-cycle cpu_ack pulse. In the cycle after the ack it either
  // drops cpu_req or presents a new request. vid_req is a per-cycle strobe with no ready.
  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_q,
    output vid_data, vid_valid, cpu_ack, cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_q,
    input  vid_data, vid_valid, cpu_ack, cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: video reads have absolute priority and zero added latency,
// the CPU is granted only in cycles where the video side leaves the RAM port idle.
module vram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 12
) (
  input  logic       clk,
  input  logic       rst,
  vram_if.slave      bus,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              w_grant;
  logic              w_stall_cycle;
  logic              r_we_lat;
  logic [DATA_W-1:0] r_rdata;
  logic [15:0]       r_stall;
  logic              r_vid_valid;

  // rst is in the grant term so no write can reach the RAM while reset is held
  assign w_grant       = (r_state == ST_IDLE) & bus.cpu_req & ~bus.vid_req & ~rst;
  assign w_stall_cycle = (r_state == ST_IDLE) & bus.cpu_req & bus.vid_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_grant) w_next_state = ST_CAPTURE;
      ST_CAPTURE: w_next_state = ST_DONE;
      ST_DONE:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we_lat    <= 1'b0;
      r_rdata     <= '0;
      r_stall     <= '0;
      r_vid_valid <= 1'b0;
    end else begin
      r_vid_valid <= bus.vid_req;
      if (w_grant) begin
        r_we_lat <= bus.cpu_we;
      end
      // The RAM returns q one cycle after the address, i.e. during CAPTURE
      if ((r_state == ST_CAPTURE) && !r_we_lat) begin
        r_rdata <= bus.mem_q;
      end
      if (w_stall_cycle && (r_stall != 16'hFFFF)) begin
        r_stall <= r_stall + 16'd1;
      end
    end
  end

  assign bus.mem_addr  = w_grant ? bus.cpu_addr : bus.vid_addr;
  assign bus.mem_wdata = bus.cpu_wdata;
  assign bus.mem_we    = w_grant & bus.cpu_we;

  assign bus.vid_data  = bus.mem_q;
  assign bus.vid_valid = r_vid_valid;
  assign bus.cpu_ack   = (r_state == ST_DONE);
  assign bus.cpu_rdata = r_rdata;
  assign bus.cpu_stall = r_stall;

  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a 16K x 12 RAM with registered address, a transaction-level model
// of the arbitration rules, directed sequences and randomized traffic.
module tb_vram_arbiter;
  localparam int AW = 14;
  localparam int DW = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  logic [1:0] dbg_state;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- RAM: address registered, q read through ----------------
  logic [DW-1:0] ram [0:16383];
  logic [AW-1:0] r_qaddr = '0;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    r_qaddr <= bus.mem_addr;
  end
  assign bus.mem_q = ram[r_qaddr];

  // ---------------- counters and check ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [DW-1:0] shadow [0:16383];
  logic [DW-1:0] exp_q [$];       // read data owed to the CPU, oldest first
  int            m_busy;          // cycles left until the arbiter is free again
  int            m_stall;
  logic          m_pend_we;
  logic [DW-1:0] m_rdata;
  logic          m_prev_vreq;
  logic [DW-1:0] m_prev_vdata;
  logic          m_ack_now;

  task automatic model_reset();
    m_busy      = 0;
    m_stall     = 0;
    m_pend_we   = 1'b0;
    m_rdata     = '0;
    m_prev_vreq = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver: one cycle, drive at negedge, check #1 later ----------------
  task automatic run_cycle(input logic r, input logic vreq, input logic [AW-1:0] vaddr,
                           input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                           input logic [DW-1:0] cwd);
    logic g;
    @(negedge clk);
    rst           = r;
    bus.vid_req   = vreq;
    bus.vid_addr  = vaddr;
    bus.cpu_req   = creq;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    #1;
    if (r) model_reset();
    g = !r && (m_busy == 0) && creq && !vreq;
    m_ack_now = (m_busy == 1);
    if (m_ack_now && !m_pend_we && exp_q.size() > 0) m_rdata = exp_q.pop_front();

    check("vid_valid", {31'd0, bus.vid_valid}, {31'd0, m_prev_vreq});
    if (m_prev_vreq) check("vid_data", {20'd0, bus.vid_data}, {20'd0, m_prev_vdata});
    check("mem_we", {31'd0, bus.mem_we}, {31'd0, g & cwe});
    check("mem_addr", {18'd0, bus.mem_addr}, {18'd0, (g ? caddr : vaddr)});
    if (g && cwe) check("mem_wdata", {20'd0, bus.mem_wdata}, {20'd0, cwd});
    check("cpu_ack", {31'd0, bus.cpu_ack}, {31'd0, m_ack_now});
    check("cpu_rdata", {20'd0, bus.cpu_rdata}, {20'd0, m_rdata});
    check("cpu_stall", {16'd0, bus.cpu_stall}, m_stall);

    // what the coming clock edge does
    if (!r) begin
      if ((m_busy == 0) && creq && vreq && (m_stall < 65535)) m_stall++;
      if (m_busy != 0) m_busy--;
      if (g) begin
        m_busy    = 2;
        m_pend_we = cwe;
        if (cwe) shadow[caddr] = cwd;
        else     exp_q.push_back(shadow[caddr]);
      end
      m_prev_vreq  = vreq;
      m_prev_vdata = shadow[vaddr];
    end
  endtask

  task automatic idle_cycle();
    run_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic          creq;
    logic          cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwd;
    logic          exp_we;
    logic          exp_ack;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wd;
  logic          v_req;
  logic [AW-1:0] v_addr;

  initial begin
    for (int i = 0; i < 16384; i++) begin
      ram[i]    = i[DW-1:0];
      shadow[i] = i[DW-1:0];
    end
    model_reset();

    vecs[0] = '{1'b1, 1'b1, 14'h0123, 12'hABC, 1'b1, 1'b0, 12'h000};
    vecs[1] = '{1'b1, 1'b1, 14'h0123, 12'hABC, 1'b0, 1'b0, 12'h000};
    vecs[2] = '{1'b1, 1'b1, 14'h0123, 12'hABC, 1'b0, 1'b1, 12'h000};
    vecs[3] = '{1'b1, 1'b0, 14'h0123, 12'h000, 1'b0, 1'b0, 12'h000};
    vecs[4] = '{1'b1, 1'b0, 14'h0123, 12'h000, 1'b0, 1'b0, 12'h000};
    vecs[5] = '{1'b1, 1'b0, 14'h0123, 12'h000, 1'b0, 1'b1, 12'hABC};
    vecs[6] = '{1'b0, 1'b0, 14'h0123, 12'h000, 1'b0, 1'b0, 12'hABC};

    // reset state
    reset_cycles(3);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_ack", {31'd0, bus.cpu_ack}, 32'd0);
    check("rst_rdata", {20'd0, bus.cpu_rdata}, 32'd0);
    check("rst_stall", {16'd0, bus.cpu_stall}, 32'd0);
    idle_cycle();

    // write 0xABC to 0x0123, then read it back
    for (int i = 0; i < 7; i++) begin
      run_cycle(1'b0, 1'b0, '0, vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd);
      check($sformatf("vec%0d_we", i), {31'd0, bus.mem_we}, {31'd0, vecs[i].exp_we});
      check($sformatf("vec%0d_ack", i), {31'd0, bus.cpu_ack}, {31'd0, vecs[i].exp_ack});
      check($sformatf("vec%0d_rdata", i), {20'd0, bus.cpu_rdata}, {20'd0, vecs[i].exp_rdata});
    end

    // continuous video reads of 0..9
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b0, 1'b1, AW'(i), 1'b0, 1'b0, '0, '0);
      check("vburst_we", {31'd0, bus.mem_we}, 32'd0);
      if (i > 0) begin
        check("vburst_valid", {31'd0, bus.vid_valid}, 32'd1);
        check("vburst_data", {20'd0, bus.vid_data}, i - 1);
      end
    end
    idle_cycle();
    check("vburst_last", {20'd0, bus.vid_data}, 32'd9);

    // CPU read blocked by 5 video cycles, then video fetches during CAPTURE/DONE
    reset_cycles(2);
    idle_cycle();
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b0, 1'b1, AW'(32 + i), 1'b1, 1'b0, 14'h0123, '0);
      check("blocked_state", {30'd0, dbg_state}, 32'd0);
    end
    run_cycle(1'b0, 1'b0, 14'h0040, 1'b1, 1'b0, 14'h0123, '0);
    check("stall5", {16'd0, bus.cpu_stall}, 32'd5);
    check("grant_addr", {18'd0, bus.mem_addr}, 32'h123);
    run_cycle(1'b0, 1'b1, 14'h0007, 1'b1, 1'b0, 14'h0123, '0);
    check("capture_noack", {31'd0, bus.cpu_ack}, 32'd0);
    run_cycle(1'b0, 1'b1, 14'h0008, 1'b1, 1'b0, 14'h0123, '0);
    check("done_ack", {31'd0, bus.cpu_ack}, 32'd1);
    check("done_rdata", {20'd0, bus.cpu_rdata}, 32'hABC);
    check("done_vdata", {20'd0, bus.vid_data}, 32'd7);
    idle_cycle();
    check("after_vdata", {20'd0, bus.vid_data}, 32'd8);

    // reset asserted in the CAPTURE cycle of a read
    run_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 14'h0005, '0);
    run_cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 14'h0005, '0);
    check("abort_ack", {31'd0, bus.cpu_ack}, 32'd0);
    check("abort_rdata", {20'd0, bus.cpu_rdata}, 32'd0);
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    run_cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 14'h0005, '0);
    check("abort_ack2", {31'd0, bus.cpu_ack}, 32'd0);
    run_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 14'h0005, '0);
    run_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 14'h0005, '0);
    run_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 14'h0005, '0);
    check("reissue_ack", {31'd0, bus.cpu_ack}, 32'd1);
    check("reissue_rdata", {20'd0, bus.cpu_rdata}, 32'd5);
    idle_cycle();

    // randomized traffic on a small address window to force read-after-write hits
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wd = '0;
    for (int n = 0; n < 2000; n++) begin
      if (!c_req && ($urandom_range(0, 2) != 0)) begin
        c_req  = 1'b1;
        c_we   = 1'($urandom_range(0, 1));
        c_addr = AW'($urandom_range(0, 31));
        c_wd   = DW'($urandom_range(0, 4095));
      end
      v_req  = ($urandom_range(0, 2) == 0);
      v_addr = AW'($urandom_range(0, 31));
      run_cycle(1'b0, v_req, v_addr, c_req, c_we, c_addr, c_wd);
      if (m_ack_now) c_req = 1'b0;
    end
    for (int i = 0; i < 4; i++) idle_cycle();

    // stall counter saturation
    for (int n = 0; n < 70000; n++) begin
      run_cycle(1'b0, 1'b1, 14'h0001, 1'b1, 1'b0, 14'h0002, '0);
    end
    check("stall_sat", {16'd0, bus.cpu_stall}, 32'hFFFF);
    idle_cycle();
    check("stall_hold", {16'd0, bus.cpu_stall}, 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video RAM arbiter between the video generator's fetch port and a CPU-side request/acknowledge port. It sits directly upstream of the video generator, replacing its private connection to the 16K x 12 video memory. The video side keeps strict priority and its native 1-cycle read latency. The CPU side is granted only in cycles the video side leaves idle, so display timing is never disturbed.

## Interface
- ADDR_W, 14, memory address width
- DATA_W, 12, memory word width
- clk  in  1  system clock (PLL output)
- rst  in  1  asynchronous, active-high reset
- vid_req  in  1  video generator wants a read this cycle
- vid_addr  in  ADDR_W  video read address
- vid_data  out  DATA_W  video read data; combinational pass-through of mem_q
- vid_valid  out  1  registered vid_req delayed one cycle; marks vid_data valid
- cpu_req  in  1  CPU access request; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req high
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req high
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  registered read data; valid when cpu_ack is high, held until the next read completes
- cpu_stall  out  16  saturating count of cycles cpu_req was denied by video priority
- mem_addr  out  ADDR_W  RAM address (RAM registers the address; q appears the next cycle)
- mem_wdata  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable
- mem_q  in  DATA_W  RAM read data

## Operation
- States: IDLE, CAPTURE, DONE.
- Grant is combinational: grant = (state == IDLE) & cpu_req & ~vid_req & ~rst.
- grant = 1: mem_addr = cpu_addr, mem_wdata = cpu_wdata, mem_we = cpu_we. Next state is CAPTURE.
- grant = 0: mem_addr = vid_addr, mem_we = 0, mem_wdata = cpu_wdata (don't-care).
- CAPTURE: at the clock edge, if the access was a read, cpu_rdata <= mem_q. Writes leave cpu_rdata unchanged. Next state is DONE.
- DONE: cpu_ack = 1 (Moore output). Next state is IDLE.
- The CPU master must drop cpu_req, or present a new request, in the cycle after it sees cpu_ack.
- Video priority is absolute. cpu_req and vid_req high in the same cycle: video wins and the CPU waits with no timeout.
- CAPTURE and DONE do not occupy the RAM port, so video reads proceed in those cycles.
- Per-access latency register records cpu_we at grant time so CAPTURE knows whether to load cpu_rdata.
- cpu_stall: +1 each cycle with state == IDLE & cpu_req & vid_req. Saturates at 0xFFFF. Cleared only by reset.
- vid_valid <= vid_req every cycle.

## Timing
- Reset (asynchronous, immediate) values: state IDLE, cpu_ack 0, cpu_rdata 0, vid_valid 0, cpu_stall 0, mem_we 0.
- While rst is high, mem_we stays 0 and no grant occurs. mem_addr follows vid_addr.
- Video read: vid_addr is presented in cycle t and vid_data is valid in t+1, the same as a direct RAM connection. The arbiter adds zero latency.
- CPU access with no contention: grant in cycle t, CAPTURE in t+1, cpu_ack in t+2. Minimum 3 cycles per access; back-to-back requests give one access every 3 cycles.
- A write lands in the RAM at the clock edge ending cycle t. A read in the same cycle, or a CPU read granted at t+1 or later, sees the new data.
- Reset during CAPTURE or DONE aborts the access: no cpu_ack is produced and cpu_rdata returns to 0. A write granted before reset asserted may already be committed.
- vid_req may toggle freely. A CPU request arriving while vid_req is continuously high waits indefinitely.

## Test plan
- Idle video, CPU write 0xABC to 0x0123, then a read of 0x0123: first cpu_ack 2 cycles after the write grant; on the read's cpu_ack, cpu_rdata = 0xABC. mem_we is high only in the write grant cycle.
- Continuous vid_req reading 0x0000..0x0009 (preloaded data = address): vid_data matches one cycle later each cycle, vid_valid is high from the second cycle, mem_we stays 0.
- CPU read request while vid_req is high for 5 cycles: no grant for 5 cycles, cpu_stall = 5. Grant occurs in the first cycle vid_req is low, cpu_ack 2 cycles later.
- Video fetch in the CAPTURE and DONE cycles of a CPU read: video data is correct and the CPU read still returns the correct word.
- Assert rst in the CAPTURE cycle of a read: cpu_ack never pulses, cpu_rdata = 0, state is IDLE. After release, a re-issued read completes normally.
- Hold cpu_req high with vid_req high for 70000 cycles: cpu_stall saturates at 0xFFFF with no wrap.
